round_sequencer: RTL and testbench

//  Game-round controller between the collision/goal detectors and the movers (raccoon_ctrl, car_ctrl).

---
 rtl/round_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_round_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// ----------------------------------------------------------------------------
// round_sequencer
//
// Game-round controller sitting between the collision/goal detectors and the
// movers (raccoon_ctrl, car_ctrl). It sequences start, hit, respawn, level-up,
// win and game-over, owns the lives and level counters, and drives the
// freeze/respawn controls so the movers halt and reposition on the right
// cycles.
//
// Every output is a register: an input sampled on cycle N is reflected on the
// outputs on cycle N+1.
//
// Ports
//   i_Clk         in   1  system clock
//   i_Reset       in   1  synchronous, active-high reset
//   i_Start       in   1  start request (level); only its rising edge acts
//   i_Collision   in   1  raccoon/car overlap (level)
//   i_Goal        in   1  raccoon reached the goal row (level)
//   o_Game_State  out  2  00 idle, 01 running, 10 win, 11 over
//   o_Lives       out  2  lives remaining
//   o_Level       out  4  current level
//   o_Freeze      out  1  1 = movers hold position
//   o_Respawn     out  1  1-cycle pulse: movers return to start positions
//   o_Hit         out  1  1-cycle pulse per life lost
//   o_Blink       out  1  sprite-hide toggle while a hit is shown, else 0
//
// Parameters
//   CLKS_PER_TICK  clocks per timer tick
//   HIT_TICKS      ticks frozen after a hit (>= 1)
//   LEVELUP_TICKS  ticks frozen between levels (>= 1)
//   GRACE_TICKS    ticks after respawn during which i_Collision is ignored
//   NUM_LIVES      lives loaded at start (1..3)
//   MAX_LEVEL      a goal reached at this level wins the game (<= 15)
// ----------------------------------------------------------------------------
module round_sequencer #(
    parameter int CLKS_PER_TICK = 250000,
    parameter int HIT_TICKS     = 100,
    parameter int LEVELUP_TICKS = 50,
    parameter int GRACE_TICKS   = 30,
    parameter int NUM_LIVES     = 3,
    parameter int MAX_LEVEL     = 9
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic       i_Collision,
    input  logic       i_Goal,
    output logic [1:0] o_Game_State,
    output logic [1:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Freeze,
    output logic       o_Respawn,
    output logic       o_Hit,
    output logic       o_Blink
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int TMAX_HL = (HIT_TICKS > LEVELUP_TICKS) ? HIT_TICKS : LEVELUP_TICKS;
    localparam int TMAX    = (TMAX_HL > GRACE_TICKS) ? TMAX_HL : GRACE_TICKS;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam int PRE_W   = $clog2(CLKS_PER_TICK + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLKS_PER_TICK - 1);
    localparam logic [TIMER_W-1:0] HIT_LAST   = TIMER_W'(HIT_TICKS - 1);
    localparam logic [TIMER_W-1:0] LVL_LAST   = TIMER_W'(LEVELUP_TICKS - 1);
    localparam logic [TIMER_W-1:0] GRACE_END  = TIMER_W'(GRACE_TICKS);
    localparam logic [1:0]         LIVES_INIT = 2'(NUM_LIVES);
    localparam logic [3:0]         LEVEL_TOP  = 4'(MAX_LEVEL);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RESPAWN  = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_HIT      = 3'd3;
    localparam logic [2:0] S_LEVEL_UP = 3'd4;
    localparam logic [2:0] S_WIN      = 3'd5;
    localparam logic [2:0] S_OVER     = 3'd6;

    localparam logic [1:0] GS_IDLE    = 2'b00;
    localparam logic [1:0] GS_RUNNING = 2'b01;
    localparam logic [1:0] GS_WIN     = 2'b10;
    localparam logic [1:0] GS_OVER    = 2'b11;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]         state;
    logic [PRE_W-1:0]   prescaler;
    logic [TIMER_W-1:0] timer;
    logic               start_q;
    logic [1:0]         lives;
    logic [3:0]         level;
    logic [1:0]         game_state;
    logic               freeze;
    logic               respawn;
    logic               hit;
    logic               blink;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [2:0]         state_n;
    logic [1:0]         lives_n;
    logic [3:0]         level_n;
    logic               blink_n;
    logic [PRE_W-1:0]   prescaler_n;
    logic [TIMER_W-1:0] timer_n;
    logic               tick;
    logic               start_edge;
    logic               graced;
    logic               entering;

    // Coarse game state reported for each FSM state. RESPAWN belongs to the
    // round in progress, so it reports "running".
    function automatic logic [1:0] game_state_of(input logic [2:0] s);
        case (s)
            S_IDLE:  game_state_of = GS_IDLE;
            S_WIN:   game_state_of = GS_WIN;
            S_OVER:  game_state_of = GS_OVER;
            default: game_state_of = GS_RUNNING;
        endcase
    endfunction

    assign tick       = (prescaler == PRE_LAST);
    assign start_edge = i_Start & ~start_q;
    // In RUN the timer saturates at GRACE_END, so this stays true once the
    // grace window has elapsed.
    assign graced     = (timer >= GRACE_END);

    // ------------------------------------------------------------------
    // Transition logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        lives_n = lives;
        level_n = level;

        case (state)
            S_IDLE, S_WIN, S_OVER: begin
                if (start_edge) begin
                    state_n = S_RESPAWN;
                    lives_n = LIVES_INIT;
                    level_n = 4'd0;
                end
            end
            S_RESPAWN: begin
                state_n = S_RUN;
            end
            S_RUN: begin
                // Collision has priority over goal; a simultaneous goal is
                // discarded and the level is left alone.
                if (i_Collision && graced) begin
                    state_n = S_HIT;
                    lives_n = lives - 2'd1;
                end else if (i_Goal) begin
                    if (level == LEVEL_TOP) begin
                        state_n = S_WIN;
                    end else begin
                        state_n = S_LEVEL_UP;
                        level_n = level + 4'd1;
                    end
                end
            end
            S_HIT: begin
                // Inputs are ignored here so a held overlap costs one life.
                if (tick && (timer == HIT_LAST)) begin
                    state_n = (lives == 2'd0) ? S_OVER : S_RESPAWN;
                end
            end
            S_LEVEL_UP: begin
                if (tick && (timer == LVL_LAST)) begin
                    state_n = S_RESPAWN;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign entering = (state_n != state);

    // ------------------------------------------------------------------
    // Tick prescaler and tick timer; both restart on every state entry so a
    // timed state lasts exactly N*CLKS_PER_TICK cycles.
    // ------------------------------------------------------------------
    always_comb begin
        prescaler_n = prescaler + PRE_W'(1);
        if (entering || tick) begin
            prescaler_n = '0;
        end

        timer_n = timer;
        if (entering) begin
            timer_n = '0;
        end else if (tick) begin
            case (state)
                S_HIT, S_LEVEL_UP: timer_n = timer + TIMER_W'(1);
                S_RUN:             if (!graced) timer_n = timer + TIMER_W'(1);
                default:           timer_n = timer;
            endcase
        end
    end

    // Blink starts high on HIT entry and flips on each tick while in HIT.
    always_comb begin
        blink_n = 1'b0;
        if (state_n == S_HIT) begin
            blink_n = (state == S_HIT) ? (blink ^ tick) : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state      <= S_IDLE;
            prescaler  <= '0;
            timer      <= '0;
            // Cleared to 1 so a start held through reset is not an edge.
            start_q    <= 1'b1;
            lives      <= LIVES_INIT;
            level      <= 4'd0;
            game_state <= GS_IDLE;
            freeze     <= 1'b1;
            respawn    <= 1'b0;
            hit        <= 1'b0;
            blink      <= 1'b0;
        end else begin
            state      <= state_n;
            prescaler  <= prescaler_n;
            timer      <= timer_n;
            start_q    <= i_Start;
            lives      <= lives_n;
            level      <= level_n;
            game_state <= game_state_of(state_n);
            freeze     <= (state_n != S_RUN);
            respawn    <= (state_n == S_RESPAWN);
            hit        <= (state_n == S_HIT) && (state != S_HIT);
            blink      <= blink_n;
        end
    end

    assign o_Game_State = game_state;
    assign o_Lives      = lives;
    assign o_Level      = level;
    assign o_Freeze     = freeze;
    assign o_Respawn    = respawn;
    assign o_Hit        = hit;
    assign o_Blink      = blink;

endmodule

// File: tb/tb_round_sequencer.sv
// ----------------------------------------------------------------------------
// tb_round_sequencer
//
// Directed scenarios followed by a random run, every cycle compared against a
// behavioural model that counts cycles spent in each game phase.
// ----------------------------------------------------------------------------
module tb_round_sequencer;

    localparam int CPT  = 4;
    localparam int HT   = 3;
    localparam int LT   = 2;
    localparam int GT   = 1;
    localparam int NL   = 3;
    localparam int MAXL = 2;

    localparam int MD_IDLE = 0;
    localparam int MD_RESP = 1;
    localparam int MD_RUN  = 2;
    localparam int MD_HIT  = 3;
    localparam int MD_LVL  = 4;
    localparam int MD_WIN  = 5;
    localparam int MD_OVER = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       coll = 1'b0;
    logic       goal = 1'b0;
    logic [1:0] o_Game_State;
    logic [1:0] o_Lives;
    logic [3:0] o_Level;
    logic       o_Freeze;
    logic       o_Respawn;
    logic       o_Hit;
    logic       o_Blink;

    round_sequencer #(
        .CLKS_PER_TICK(CPT),
        .HIT_TICKS(HT),
        .LEVELUP_TICKS(LT),
        .GRACE_TICKS(GT),
        .NUM_LIVES(NL),
        .MAX_LEVEL(MAXL)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Start(start),
        .i_Collision(coll),
        .i_Goal(goal),
        .o_Game_State(o_Game_State),
        .o_Lives(o_Lives),
        .o_Level(o_Level),
        .o_Freeze(o_Freeze),
        .o_Respawn(o_Respawn),
        .o_Hit(o_Hit),
        .o_Blink(o_Blink)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: game phase plus cycles spent in it.
    int m_mode  = MD_IDLE;
    int m_cyc   = 0;
    int m_lives = NL;
    int m_level = 0;
    bit m_sprev = 1'b1;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit s, input bit c, input bit g, input bit r);
        int  nm;
        bit  edge_s;
        if (r) begin
            m_mode = MD_IDLE; m_cyc = 0; m_lives = NL; m_level = 0; m_sprev = 1'b1;
            return;
        end
        edge_s  = s && !m_sprev;
        m_sprev = s;
        nm      = m_mode;
        case (m_mode)
            MD_IDLE, MD_WIN, MD_OVER:
                if (edge_s) begin nm = MD_RESP; m_lives = NL; m_level = 0; end
            MD_RESP: nm = MD_RUN;
            MD_RUN:
                if (c && m_cyc >= GT * CPT) begin
                    nm = MD_HIT; m_lives = m_lives - 1;
                end else if (g) begin
                    if (m_level == MAXL) nm = MD_WIN;
                    else begin nm = MD_LVL; m_level = m_level + 1; end
                end
            MD_HIT: if (m_cyc == HT * CPT - 1) nm = (m_lives == 0) ? MD_OVER : MD_RESP;
            MD_LVL: if (m_cyc == LT * CPT - 1) nm = MD_RESP;
            default: ;
        endcase
        if (nm != m_mode) begin m_mode = nm; m_cyc = 0; end
        else m_cyc = m_cyc + 1;
    endtask

    function automatic logic [11:0] m_vec();
        logic [1:0] gs;
        gs = (m_mode == MD_IDLE) ? 2'b00 : (m_mode == MD_WIN) ? 2'b10 :
             (m_mode == MD_OVER) ? 2'b11 : 2'b01;
        return {gs, 2'(m_lives), 4'(m_level), (m_mode != MD_RUN), (m_mode == MD_RESP),
                (m_mode == MD_HIT && m_cyc == 0),
                (m_mode == MD_HIT && ((m_cyc / CPT) % 2 == 0))};
    endfunction

    task automatic step(input bit s, input bit c, input bit g, input bit r);
        logic [11:0] mask;
        logic [11:0] obs;
        start = s; coll = c; goal = g; rst = r;
        @(posedge clk);
        model_step(s, c, g, r);
        #1;
        // Game state during the one respawn cycle is not checked.
        mask = (m_mode == MD_RESP) ? 12'h3FF : 12'hFFF;
        obs  = {o_Game_State, o_Lives, o_Level, o_Freeze, o_Respawn, o_Hit, o_Blink};
        chk("cycle", obs & mask, m_vec() & mask);
        @(negedge clk);
    endtask

    initial begin
        int          hits;
        logic [5:0]  lives_seq;
        bit          rs, rc, rg, rr;

        // Reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_state", 12'(o_Game_State), 12'd0);
        chk("reset_lives", 12'(o_Lives), 12'd3);
        chk("reset_level", 12'(o_Level), 12'd0);
        chk("reset_freeze", 12'(o_Freeze), 12'd1);

        // Start edge -> respawn pulse -> RUN
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("start_respawn", 12'(o_Respawn), 12'd1);
        step(1, 0, 0, 0);
        chk("run_state", 12'(o_Game_State), 12'd1);
        chk("run_freeze", 12'(o_Freeze), 12'd0);

        // Collision inside grace ignored, later collision taken
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("grace_lives", 12'(o_Lives), 12'd3);
        chk("grace_freeze", 12'(o_Freeze), 12'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("hit_pulse", 12'(o_Hit), 12'd1);
        chk("hit_lives", 12'(o_Lives), 12'd2);
        for (int i = 1; i < 12; i++) begin
            step(1, 0, 0, 0);
            chk("hit_freeze", 12'(o_Freeze), 12'd1);
            chk("hit_blink", 12'(o_Blink), 12'((i / 4) % 2 == 0));
        end
        step(1, 0, 0, 0);
        chk("hit_respawn", 12'(o_Respawn), 12'd1);
        step(1, 0, 0, 0);

        // Collision and goal together: hit wins, level unchanged
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("both_hit", 12'(o_Hit), 12'd1);
        chk("both_lives", 12'(o_Lives), 12'd1);
        chk("both_level", 12'(o_Level), 12'd0);
        for (int i = 0; i < 13; i++) step(1, 0, 0, 0);

        // Held collision runs out the last life
        for (int i = 0; i < 40 && o_Game_State != 2'b11; i++) step(1, 1, 0, 0);
        chk("over_state1", 12'(o_Game_State), 12'd3);

        // Fresh game, collision held throughout: lives 2,1,0 then OVER
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("restart_respawn", 12'(o_Respawn), 12'd1);
        chk("restart_lives", 12'(o_Lives), 12'd3);
        hits = 0; lives_seq = '0;
        for (int i = 0; i < 200 && o_Game_State != 2'b11; i++) begin
            step(1, 1, 0, 0);
            if (o_Hit) begin hits++; lives_seq = {lives_seq[3:0], o_Lives}; end
        end
        chk("hit_count", 12'(hits), 12'd3);
        chk("lives_seq", 12'(lives_seq), 12'b10_01_00);
        chk("over_state", 12'(o_Game_State), 12'd3);
        chk("over_freeze", 12'(o_Freeze), 12'd1);

        // Goals: level 0 -> 1 -> 2 -> WIN
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("new_game_lives", 12'(o_Lives), 12'd3);
        step(1, 0, 0, 0);
        for (int lv = 1; lv <= 2; lv++) begin
            step(1, 0, 1, 0);
            chk("lvl_level", 12'(o_Level), 12'(lv));
            for (int i = 1; i < 8; i++) begin
                step(1, 0, 0, 0);
                chk("lvl_freeze", 12'(o_Freeze), 12'd1);
            end
            step(1, 0, 0, 0);
            chk("lvl_respawn", 12'(o_Respawn), 12'd1);
            step(1, 0, 0, 0);
        end
        step(1, 0, 1, 0);
        chk("win_state", 12'(o_Game_State), 12'd2);
        chk("win_level", 12'(o_Level), 12'd2);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("win_restart_level", 12'(o_Level), 12'd0);
        step(1, 0, 0, 0);

        // Reset mid-HIT with start held high
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("midhit_reset", {o_Game_State, o_Lives, o_Level, o_Freeze, o_Respawn, o_Hit, o_Blink},
            12'b00_11_0000_1_0_0_0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("held_start_idle", 12'(o_Game_State), 12'd0);
        end
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("repress_respawn", 12'(o_Respawn), 12'd1);

        // Random run
        rs = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rs = ~rs;
            rc = ($urandom_range(7) == 0);
            rg = ($urandom_range(15) == 0);
            rr = ($urandom_range(299) == 0);
            step(rs, rc, rg, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
